// File: rtl/div_iter.sv
// Iterative restoring radix-2 divider for the execute stage.
// One quotient bit per cycle, then a single fix-up cycle for signs and
// divide-by-zero, then a one-cycle result pulse. No backpressure on output.
module div_iter #(
    parameter int unsigned W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             s_valid,
    input  logic             s_signed,
    input  logic [W-1:0]     s_dividend,
    input  logic [W-1:0]     s_divisor,
    input  logic             cancel,
    output logic             s_ready,
    output logic             m_valid,
    output logic [2*W-1:0]   m_tdata
);

    localparam int unsigned CNT_W = 6;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [W-1:0]     rem;
    logic [W-1:0]     quo;
    logic [W-1:0]     dvs;
    logic [W-1:0]     orig_dividend;
    logic             neg_quo;
    logic             neg_rem;
    logic             div_zero;
    logic [CNT_W-1:0] cnt;

    logic             accept_c;
    logic [W-1:0]     abs_dividend_c;
    logic [W-1:0]     abs_divisor_c;
    logic [W:0]       trial_c;
    logic [W:0]       diff_c;
    logic             ge_c;
    logic [W-1:0]     quo_fix_c;
    logic [W-1:0]     rem_fix_c;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; cancel aborts BUSY/FIX but never a pending DONE pulse
    always_comb begin
        next_state = state;
        accept_c   = 1'b0;
        case (state)
            IDLE: begin
                if (s_valid && !cancel) begin
                    accept_c   = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (cancel) begin
                    next_state = IDLE;
                end else if (cnt == LAST_STEP) begin
                    next_state = FIX;
                end
            end
            FIX: begin
                if (cancel) begin
                    next_state = IDLE;
                end else begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand magnitudes, restoring step and final sign/zero fix-up
    always_comb begin
        abs_dividend_c = (s_signed && s_dividend[W-1]) ? (~s_dividend + W'(1)) : s_dividend;
        abs_divisor_c  = (s_signed && s_divisor[W-1])  ? (~s_divisor + W'(1))  : s_divisor;
        trial_c        = {rem, quo[W-1]};
        ge_c           = (trial_c >= {1'b0, dvs});
        diff_c         = trial_c - {1'b0, dvs};
        quo_fix_c      = div_zero ? {W{1'b1}} : (neg_quo ? (~quo + W'(1)) : quo);
        rem_fix_c      = div_zero ? orig_dividend : (neg_rem ? (~rem + W'(1)) : rem);
    end

    // Datapath: capture on accept, iterate in BUSY, publish result in FIX
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem           <= '0;
            quo           <= '0;
            dvs           <= '0;
            orig_dividend <= '0;
            neg_quo       <= 1'b0;
            neg_rem       <= 1'b0;
            div_zero      <= 1'b0;
            cnt           <= '0;
            m_tdata       <= '0;
        end else begin
            if (accept_c) begin
                rem           <= '0;
                quo           <= abs_dividend_c;
                dvs           <= abs_divisor_c;
                orig_dividend <= s_dividend;
                neg_quo       <= s_signed && (s_dividend[W-1] != s_divisor[W-1]);
                neg_rem       <= s_signed && s_dividend[W-1];
                div_zero      <= (s_divisor == '0);
                cnt           <= '0;
            end else if (state == BUSY && !cancel) begin
                rem <= W'(ge_c ? diff_c : trial_c);
                quo <= {quo[W-2:0], ge_c};
                cnt <= cnt + CNT_W'(1);
            end
            if (state == FIX && !cancel) begin
                m_tdata <= {quo_fix_c, rem_fix_c};
            end
        end
    end

    // Registered handshake outputs, derived from the upcoming state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
        end else begin
            m_valid <= (next_state == DONE);
            s_ready <= (next_state == IDLE);
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: latency, sign handling, divide-by-zero,
// cancel, mid-operation reset and back-to-back acceptance.
`timescale 1ns/1ps
module tb_div_iter;

    logic        clk;
    logic        resetn;
    logic        s_valid;
    logic        s_signed;
    logic [31:0] s_dividend;
    logic [31:0] s_divisor;
    logic        cancel;
    logic        s_ready;
    logic        m_valid;
    logic [63:0] m_tdata;

    int n_cmp;
    int n_err;

    div_iter #(.W(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .s_valid    (s_valid),
        .s_signed   (s_signed),
        .s_dividend (s_dividend),
        .s_divisor  (s_divisor),
        .cancel     (cancel),
        .s_ready    (s_ready),
        .m_valid    (m_valid),
        .m_tdata    (m_tdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Cycle k is the interval sampled by the k-th edge after acceptance;
    // values are observed at the negedge inside that interval.
    task automatic run(input string tag, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input int cancel_cyc,
                       input logic [63:0] exp, input bit pulse);
        logic [63:0] prev;
        prev = m_tdata;
        @(negedge clk);
        s_valid = 1'b1; s_signed = sgn; s_dividend = a; s_divisor = b; cancel = 1'b0;
        check({tag, " ready_c0"}, 64'(s_ready), 64'(1));
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            s_valid    = 1'b0;
            s_signed   = ~sgn;
            s_dividend = $urandom;
            s_divisor  = $urandom;
            cancel     = (k == cancel_cyc);
            check($sformatf("%s valid_c%0d", tag, k), 64'(m_valid), 64'(pulse && k == 34));
            if (k == 1)
                check({tag, " ready_c1"}, 64'(s_ready), 64'(0));
            if (pulse && k == 34) begin
                check({tag, " ready_c34"}, 64'(s_ready), 64'(0));
                check({tag, " data"}, m_tdata, exp);
            end
            if (pulse && k == 35)
                check({tag, " ready_c35"}, 64'(s_ready), 64'(1));
            if (!pulse && k == cancel_cyc + 1)
                check({tag, " ready_after_cancel"}, 64'(s_ready), 64'(1));
        end
        cancel = 1'b0;
        if (!pulse)
            check({tag, " data_held"}, m_tdata, prev);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        resetn = 1'b0; s_valid = 1'b0; s_signed = 1'b0;
        s_dividend = '0; s_divisor = '0; cancel = 1'b0;
        #1;
        check("rst valid", 64'(m_valid), 64'(0));
        check("rst data", m_tdata, 64'(0));
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        run("u100_7",   1'b0, 32'd100,        32'd7,          -1, {32'h0000000E, 32'h00000002}, 1'b1);
        run("s-7_2",    1'b1, 32'hFFFFFFF9,   32'd2,          -1, {32'hFFFFFFFD, 32'hFFFFFFFF}, 1'b1);
        run("s7_-2",    1'b1, 32'd7,          32'hFFFFFFFE,   -1, {32'hFFFFFFFD, 32'h00000001}, 1'b1);
        run("uF9_2",    1'b0, 32'hFFFFFFF9,   32'd2,          -1, {32'h7FFFFFFC, 32'h00000001}, 1'b1);
        run("s_ovf",    1'b1, 32'h80000000,   32'hFFFFFFFF,   -1, {32'h80000000, 32'h00000000}, 1'b1);
        run("s-5_0",    1'b1, 32'hFFFFFFFB,   32'd0,          -1, {32'hFFFFFFFF, 32'hFFFFFFFB}, 1'b1);
        run("u5_0",     1'b0, 32'd5,          32'd0,          -1, {32'hFFFFFFFF, 32'h00000005}, 1'b1);
        run("cancel10", 1'b0, 32'd50,         32'd5,          10, 64'h0,                        1'b0);
        run("u9_3",     1'b0, 32'd9,          32'd3,          -1, {32'h00000003, 32'h00000000}, 1'b1);
        run("cancelD",  1'b0, 32'd20,         32'd6,          34, {32'h00000003, 32'h00000002}, 1'b1);

        // cancel while idle blocks acceptance
        @(negedge clk);
        s_valid = 1'b1; cancel = 1'b1; s_signed = 1'b0; s_dividend = 32'd1; s_divisor = 32'd1;
        @(negedge clk);
        s_valid = 1'b0; cancel = 1'b0;
        check("idle_cancel ready", 64'(s_ready), 64'(1));
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            check($sformatf("idle_cancel valid_c%0d", k), 64'(m_valid), 64'(0));
        end

        // reset in the middle of a division
        @(negedge clk);
        s_valid = 1'b1; s_signed = 1'b0; s_dividend = 32'd1000; s_divisor = 32'd10;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
        resetn = 1'b0;
        #1;
        check("midrst valid", 64'(m_valid), 64'(0));
        check("midrst data", m_tdata, 64'(0));
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("midrst ready", 64'(s_ready), 64'(1));
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            check($sformatf("midrst valid_c%0d", k), 64'(m_valid), 64'(0));
        end

        // back-to-back with s_valid held high
        @(negedge clk);
        s_valid = 1'b1; s_signed = 1'b0; s_dividend = 32'd100; s_divisor = 32'd7;
        for (int k = 1; k <= 72; k++) begin
            @(negedge clk);
            if (k == 1) begin
                s_dividend = 32'd9; s_divisor = 32'd3;
            end
            if (k == 36) s_valid = 1'b0;
            check($sformatf("b2b valid_c%0d", k), 64'(m_valid), 64'(k == 34 || k == 69));
            if (k == 34) check("b2b data0", m_tdata, {32'h0000000E, 32'h00000002});
            if (k == 35) check("b2b ready_c35", 64'(s_ready), 64'(1));
            if (k == 36) check("b2b ready_c36", 64'(s_ready), 64'(0));
            if (k == 69) check("b2b data1", m_tdata, {32'h00000003, 32'h00000000});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 Parameter: W, 32, operand width; only W=32 is supported and verified.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: resetn  input  1  asynchronous, active-low reset.
REQ-004 Port: s_valid  input  1  request strobe; the operands are captured when s_valid && s_ready.
REQ-005 Port: s_signed  input  1  1 selects signed division and 0 selects unsigned division; captured with the operands.
REQ-006 Port: s_dividend  input  32  dividend (rj).
REQ-007 Port: s_divisor  input  32  divisor (rk).
REQ-008 Port: cancel  input  1  flush from the pipeline; aborts an in-flight division.
REQ-009 Port: s_ready  output  1  high only in IDLE.
REQ-010 Port: m_valid  output  1  single-cycle result pulse; there is no backpressure.
REQ-011 Port: m_tdata  output  64  {quotient[63:32], remainder[31:0]}, matching the execute-stage result-mux slicing.

Function
REQ-012 The FSM SHALL have states IDLE, BUSY, FIX and DONE.
REQ-013 IDLE -> BUSY SHALL occur on s_valid && s_ready && !cancel.
REQ-014 On that transition the block SHALL latch the sign flags, the absolute values of both operands (absolute value only when s_signed), the original dividend, and a 6-bit iteration counter cleared to 0.
REQ-015 BUSY SHALL perform one restoring radix-2 step per cycle: {rem,quo} shifted left 1; if rem >= |divisor|, subtract and set quo[0]=1.
REQ-016 The iteration counter SHALL increment on every BUSY step, and BUSY -> FIX SHALL occur after the 32nd step (counter == 31).
REQ-017 In FIX the block SHALL negate the quotient when s_signed && (sign(dividend) != sign(divisor)).
REQ-018 In FIX the block SHALL negate the remainder when s_signed && dividend is negative.
REQ-019 FIX SHALL then go to DONE.
REQ-020 In DONE, m_valid SHALL be 1 for exactly one cycle, and DONE -> IDLE SHALL occur unconditionally.
REQ-021 Latency: the acceptance edge is cycle 0 and m_valid SHALL be high during cycle 34, i.e. 32 BUSY cycles, 1 FIX cycle, then DONE.
REQ-022 Throughput: the next request SHALL be acceptable no earlier than cycle 35.
REQ-023 m_tdata SHALL hold the last result stable until the next FIX cycle.
REQ-024 m_tdata SHALL NOT be qualified by m_valid for stability.
REQ-025 Signed division SHALL truncate toward zero, and the remainder sign SHALL follow the dividend.
REQ-026 Divide by zero: quotient SHALL be 0xFFFFFFFF and remainder SHALL be the original dividend for both signedness modes, with sign fix suppressed.
REQ-027 The divide-by-zero result SHALL be delivered with the normal 34-cycle latency.
REQ-028 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give quotient 0x80000000 and remainder 0, produced by the normal datapath.
REQ-029 cancel in BUSY or FIX SHALL force IDLE on the next edge, with no m_valid and m_tdata unchanged.
REQ-030 cancel in IDLE SHALL block acceptance in that cycle.
REQ-031 cancel in DONE SHALL be ignored, and the pulse SHALL still be issued.
REQ-032 s_valid while s_ready=0 SHALL be ignored, with no queueing.
REQ-033 Operand changes after acceptance SHALL have no effect.
REQ-034 The upstream ALU SHALL hold s_valid low after acceptance; the block SHALL NOT depend on this.

Reset
REQ-035 resetn low SHALL asynchronously force state IDLE, counter 0, m_valid 0, m_tdata 0, and all internal operand registers 0.
REQ-036 Reset asserted mid-division SHALL discard the operation, and no m_valid SHALL follow deassertion.
REQ-037 s_ready SHALL be 1 in the first cycle after resetn deasserts, with no warm-up cycles.

Verification
REQ-038 Unsigned 100 / 7 -> m_valid at cycle 34, m_tdata = {0x0000000E, 0x00000002}; s_ready low for cycles 1-34.
REQ-039 Signed -7 / 2 -> {0xFFFFFFFD, 0xFFFFFFFF}; signed 7 / -2 -> {0xFFFFFFFD, 0x00000001}; unsigned 0xFFFFFFF9 / 2 -> {0x7FFFFFFC, 0x00000001}.
REQ-040 Signed 0x80000000 / 0xFFFFFFFF -> {0x80000000, 0x00000000}; signed -5 / 0 -> {0xFFFFFFFF, 0xFFFFFFFB}.
REQ-041 Accept 50 / 5, pulse cancel at cycle 10 -> no m_valid through cycle 40, s_ready = 1 at cycle 11, and a new request 9 / 3 -> {3, 0} at +34.
REQ-042 resetn low at cycle 20 of a division -> m_valid 0 and m_tdata 0 immediately, no pulse afterwards, s_ready = 1 after release.
REQ-043 Back-to-back: s_valid held high continuously -> accepts at cycles 0 and 35, m_valid pulses at 34 and 69, each exactly one cycle wide.
